// File: rtl/vram_pkg.sv
// Shared VRAM fill definitions: fill FSM state encoding, framebuffer geometry
// defaults and the linear pixel-address helper.
package vram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_t;

   localparam int unsigned FB_WIDTH_DEF = 16;
   localparam int unsigned DEPTH_DEF    = 256;
   localparam int unsigned ROWS_DEF     = DEPTH_DEF / FB_WIDTH_DEF;

   // Callers truncate the result to the VRAM address width.
   function automatic logic [31:0] pix_addr(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [31:0] fb_width);
      return (y * fb_width) + x;
   endfunction

endpackage

// File: rtl/m_raster_counter.sv
// Raster x/y counters for one rectangle: load origin/size, advance on step,
// flag the final pixel. Coordinates are one bit wider than the inputs so the
// end coordinates never wrap.
module m_raster_counter #(
   parameter int unsigned COORD_W = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] w,
   input  logic [COORD_W-1:0] h,
   output logic [COORD_W:0]   x,
   output logic [COORD_W:0]   y,
   output logic               last
);

   localparam logic [COORD_W:0] ONE = {{COORD_W{1'b0}}, 1'b1};

   logic [COORD_W:0] x0_q;
   logic [COORD_W:0] x_end_q;
   logic [COORD_W:0] y_end_q;
   logic             x_wrap;

   assign x_wrap = (x == x_end_q);
   assign last   = x_wrap && (y == y_end_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0_q    <= '0;
         x_end_q <= '0;
         y_end_q <= '0;
         x       <= '0;
         y       <= '0;
      end else if (load) begin
         x0_q    <= {1'b0, x0};
         x_end_q <= {1'b0, x0} + {1'b0, w} - ONE;
         y_end_q <= {1'b0, y0} + {1'b0, h} - ONE;
         x       <= {1'b0, x0};
         y       <= {1'b0, y0};
      end else if (step) begin
         if (x_wrap) begin
            x <= x0_q;
            y <= y + ONE;
         end else begin
            x <= x + ONE;
         end
      end
   end

endmodule

// File: rtl/m_vram_fill_sched.sv
// Rectangle-fill sequencer sharing the single VRAM port with display readout
// (reads always win). Optional FILL_PIXEL_COUNT_EN adds the pix_count output.
module m_vram_fill_sched
   import vram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned DEPTH      = DEPTH_DEF,
   parameter int unsigned FB_WIDTH   = FB_WIDTH_DEF,
   parameter int unsigned COORD_W    = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [COORD_W-1:0]    cmd_x0,
   input  logic [COORD_W-1:0]    cmd_y0,
   input  logic [COORD_W-1:0]    cmd_w,
   input  logic [COORD_W-1:0]    cmd_h,
   input  logic [DATA_WIDTH-1:0] cmd_color,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ADDR_WIDTH-1:0] vram_addr,
   output logic                  vram_write,
   output logic [DATA_WIDTH-1:0] vram_wdata,
   output logic                  busy,
   output logic                  done
`ifdef FILL_PIXEL_COUNT_EN
   ,
   output logic [15:0]           pix_count
`endif
);

   localparam int unsigned      ROWS      = DEPTH / FB_WIDTH;
   localparam logic [COORD_W:0] FB_W_LIM  = (COORD_W + 1)'(FB_WIDTH);
   localparam logic [COORD_W:0] ROWS_LIM  = (COORD_W + 1)'(ROWS);

   fill_state_t           state_q;
   fill_state_t           state_d;
   logic [DATA_WIDTH-1:0] color_q;
   logic [COORD_W:0]      x;
   logic [COORD_W:0]      y;
   logic                  last;
   logic                  accept;
   logic                  empty;
   logic                  step;
   logic                  in_bounds;
   logic [ADDR_WIDTH-1:0] pix_addr_w;

   assign accept = cmd_valid && cmd_ready;
   assign empty  = (cmd_w == '0) || (cmd_h == '0);
   assign step   = (state_q == FILL) && !rd_req;

   m_raster_counter #(
      .COORD_W (COORD_W)
   ) u_raster (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .step  (step),
      .x0    (cmd_x0),
      .y0    (cmd_y0),
      .w     (cmd_w),
      .h     (cmd_h),
      .x     (x),
      .y     (y),
      .last  (last)
   );

   // Clipped pixels still take a step; they just never reach the port.
   assign in_bounds  = (x < FB_W_LIM) && (y < ROWS_LIM);
   assign pix_addr_w = ADDR_WIDTH'(pix_addr(32'(x), 32'(y), 32'(FB_WIDTH)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            color_q <= cmd_color;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cmd_ready  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = empty ? DONE : FILL;
            end
         end
         FILL: begin
            busy = 1'b1;
            if (step && last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign vram_addr  = rd_req ? rd_addr : pix_addr_w;
   assign vram_write = step && in_bounds;
   assign vram_wdata = busy ? color_q : '0;

`ifdef FILL_PIXEL_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_count <= '0;
      end else if (accept) begin
         pix_count <= '0;
      end else if (vram_write && (pix_count != '1)) begin
         pix_count <= pix_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_m_vram_fill_sched.sv
// Scoreboard bench for m_vram_fill_sched: stimulus queues expected writes and
// done cycles, a negedge monitor pops and compares.
module tb_m_vram_fill_sched;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 4;
   localparam int unsigned CW = 11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [CW-1:0] cmd_x0 = '0;
   logic [CW-1:0] cmd_y0 = '0;
   logic [CW-1:0] cmd_w = '0;
   logic [CW-1:0] cmd_h = '0;
   logic [DW-1:0] cmd_color = '0;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [AW-1:0] vram_addr;
   logic          vram_write;
   logic [DW-1:0] vram_wdata;
   logic          busy;
   logic          done;
`ifdef FILL_PIXEL_COUNT_EN
   logic [15:0]   pix_count;
`endif

   m_vram_fill_sched #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (256),
      .FB_WIDTH   (16),
      .COORD_W    (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_x0     (cmd_x0),
      .cmd_y0     (cmd_y0),
      .cmd_w      (cmd_w),
      .cmd_h      (cmd_h),
      .cmd_color  (cmd_color),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .vram_addr  (vram_addr),
      .vram_write (vram_write),
      .vram_wdata (vram_wdata),
      .busy       (busy),
      .done       (done)
`ifdef FILL_PIXEL_COUNT_EN
      ,
      .pix_count  (pix_count)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t wq[$];
   int  dq[$];
   int  checks = 0;
   int  errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor: every write and done pulse must match the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (vram_write) begin
            if (wq.size() == 0) begin
               fail_now($sformatf("unexpected_write addr=%0d", vram_addr));
            end else begin
               wr_t e;
               e = wq.pop_front();
               check("write_addr", 32'(vram_addr), 32'(e.addr));
               check("write_data", 32'(vram_wdata), 32'(e.data));
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               fail_now("unexpected_done");
            end else begin
               int d;
               d = dq.pop_front();
               check("done_cycle", 32'(cyc), 32'(d));
            end
         end
         if (!busy) begin
            check("idle_wdata", 32'(vram_wdata), 32'd0);
         end
      end
   end

   task automatic push_expected(input int x0, input int y0, input int w, input int h,
                                input logic [DW-1:0] col, input int maxn);
      int n = 0;
      for (int yy = y0; yy < y0 + h; yy++) begin
         for (int xx = x0; xx < x0 + w; xx++) begin
            if (n < maxn && xx < 16 && yy < 16) begin
               wr_t e;
               e.addr = AW'(yy * 16 + xx);
               e.data = col;
               wq.push_back(e);
               n++;
            end
         end
      end
   endtask

   task automatic issue(input int x0, input int y0, input int w, input int h,
                        input logic [DW-1:0] col, output int acc);
      int t = 0;
      while (!cmd_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!cmd_ready) fail_now("cmd_ready_timeout");
      cmd_x0    = CW'(x0);
      cmd_y0    = CW'(y0);
      cmd_w     = CW'(w);
      cmd_h     = CW'(h);
      cmd_color = col;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      acc       = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while (dq.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (dq.size() != 0) begin
         fail_now({name, "_done_timeout"});
         dq.delete();
      end
      @(posedge clk); #1;
      check({name, "_writes_left"}, 32'(wq.size()), 32'd0);
      wq.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int acc;
      int acc2;

      // Reset values while held in reset
      #3;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_vram_write", 32'(vram_write), 32'd0);
      check("rst_vram_wdata", 32'(vram_wdata), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;

      // Basic fill
      push_expected(2, 3, 3, 2, 4'hA, 99);
      issue(2, 3, 3, 2, 4'hA, acc);
      dq.push_back(acc + 6);
      wait_drain("basic");
`ifdef FILL_PIXEL_COUNT_EN
      check("basic_pix_count", 32'(pix_count), 32'd6);
`endif

      // Contention: three-cycle display stall after two writes
      push_expected(2, 3, 3, 2, 4'hA, 99);
      issue(2, 3, 3, 2, 4'hA, acc);
      dq.push_back(acc + 9);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rd_req  = 1'b1;
      rd_addr = 8'hC3;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("stall_addr", 32'(vram_addr), 32'hC3);
         check("stall_write", 32'(vram_write), 32'd0);
         check("stall_wdata", 32'(vram_wdata), 32'hA);
         @(posedge clk); #1;
      end
      rd_req = 1'b0;
      wait_drain("contention");
`ifdef FILL_PIXEL_COUNT_EN
      check("contention_pix_count", 32'(pix_count), 32'd6);
`endif

      // Clipping at the bottom-right corner
      push_expected(14, 15, 4, 2, 4'h3, 99);
      issue(14, 15, 4, 2, 4'h3, acc);
      dq.push_back(acc + 8);
      wait_drain("clip");
`ifdef FILL_PIXEL_COUNT_EN
      check("clip_pix_count", 32'(pix_count), 32'd2);
`endif

      // Empty command followed by a back-to-back command held valid
      cmd_x0 = 11'd5; cmd_y0 = 11'd5; cmd_w = 11'd0; cmd_h = 11'd3; cmd_color = 4'h7;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      dq.push_back(acc);
      check("empty_ready_in_done", 32'(cmd_ready), 32'd0);
      check("empty_busy_in_done", 32'(busy), 32'd1);
      cmd_x0 = 11'd0; cmd_y0 = 11'd0; cmd_w = 11'd2; cmd_h = 11'd1; cmd_color = 4'h5;
      push_expected(0, 0, 2, 1, 4'h5, 99);
      @(posedge clk); #1;
      check("b2b_ready_after_done", 32'(cmd_ready), 32'd1);
      check("b2b_busy_after_done", 32'(busy), 32'd0);
      @(posedge clk); #1;
      acc2 = cyc;
      cmd_valid = 1'b0;
      check("b2b_accept_cycle", 32'(acc2), 32'(acc + 2));
      dq.push_back(acc2 + 2);
      wait_drain("b2b");
`ifdef FILL_PIXEL_COUNT_EN
      check("b2b_pix_count", 32'(pix_count), 32'd2);
`endif

      // Reset mid-fill after two of six writes
      push_expected(2, 3, 3, 2, 4'hA, 2);
      issue(2, 3, 3, 2, 4'hA, acc);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_write", 32'(vram_write), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_ready", 32'(cmd_ready), 32'd1);
      check("midrst_wdata", 32'(vram_wdata), 32'd0);
`ifdef FILL_PIXEL_COUNT_EN
      check("midrst_pix_count", 32'(pix_count), 32'd0);
`endif
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      check("midrst_writes_left", 32'(wq.size()), 32'd0);
      check("midrst_busy_after", 32'(busy), 32'd0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
